fifo_rd_out_stage: RTL and testbench

//  Read-domain output stage of the async FIFO. Sits directly downstream of the

---
 rtl/fifo_rd_out_stage.sv | 90 +++++++++
 tb/tb_fifo_rd_out_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_out_stage.sv
// Read-domain output stage of the async FIFO: pops the FIFO into a 2-entry
// head/skid buffer and presents words on a valid/ready handshake.
module fifo_rd_out_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  R_EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RINC,
  input  logic                  FLUSH,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [1:0]            OCCUPANCY
);

  // Encoding doubles as the local word count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  push;
  logic                  pop;

  // Pop request looks only at registered state, so the consumer's ready
  // never reaches the read-pointer block combinationally.
  assign push      = R_RST && !R_EMPTY && (state_q != ST_TWO) && !FLUSH;
  assign RINC      = push;
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign OUT_DATA  = head_q;
  assign OCCUPANCY = state_q;
  assign pop       = OUT_VALID && OUT_READY;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            head_d  = RD_DATA;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_d = ST_TWO;
            skid_d  = RD_DATA;
          end else if (push && pop) begin
            head_d  = RD_DATA;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: head/skid are reset too so OUT_DATA reads 0 out of reset, not X.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_out_stage.sv
// Self-checking bench: a queue-based FIFO source and a queue model of the
// local buffer predict RINC, OUT_VALID, OUT_DATA and OCCUPANCY every cycle.
module tb_fifo_rd_out_stage;
  localparam int DW = 8;

  logic          R_CLK = 1'b0;
  logic          R_RST = 1'b0;
  logic          R_EMPTY = 1'b1;
  logic [DW-1:0] RD_DATA = '0;
  logic          RINC;
  logic          FLUSH = 1'b0;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [1:0]    OCCUPANCY;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] src[$];   // words still in the FIFO
  logic [DW-1:0] loc[$];   // words the stage should hold, head first
  logic [DW-1:0] got[$];   // words observed leaving the stage
  logic [DW-1:0] wr[$];    // words written for the current scenario

  fifo_rd_out_stage #(.DATA_WIDTH(DW)) dut (
    .R_CLK     (R_CLK),
    .R_RST     (R_RST),
    .R_EMPTY   (R_EMPTY),
    .RD_DATA   (RD_DATA),
    .RINC      (RINC),
    .FLUSH     (FLUSH),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OCCUPANCY (OCCUPANCY)
  );

  always #5 R_CLK = ~R_CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    R_EMPTY = (src.size() == 0);
    RD_DATA = (src.size() != 0) ? src[0] : DW'($urandom);
  endtask

  task automatic load(input logic [DW-1:0] w);
    src.push_back(w);
    wr.push_back(w);
  endtask

  // One clock: called just after a rising edge, returns just after the next.
  task automatic cycle(input logic rdy, input logic fl);
    bit            exp_rinc;
    bit            exp_valid;
    logic [DW-1:0] obs;
    OUT_READY = rdy;
    FLUSH     = fl;
    drive_src();
    #1;
    exp_valid = (loc.size() != 0);
    exp_rinc  = (src.size() != 0) && (loc.size() < 2) && !fl;
    check("rinc", 32'(RINC), 32'(exp_rinc));
    check("valid", 32'(OUT_VALID), 32'(exp_valid));
    check("occ", 32'(OCCUPANCY), loc.size());
    if (exp_valid) check("data", 32'(OUT_DATA), 32'(loc[0]));
    obs = OUT_DATA;
    @(posedge R_CLK);
    if (fl) begin
      loc.delete();
    end else begin
      if (exp_valid && rdy) begin
        got.push_back(obs);
        void'(loc.pop_front());
      end
      if (exp_rinc) loc.push_back(src.pop_front());
    end
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((src.size() != 0 || loc.size() != 0) && k < budget) begin
      cycle(1'b1, 1'b0);
      k++;
    end
    check({tag, "_drained"}, src.size() + loc.size(), 0);
  endtask

  task automatic cmp_seq(input string tag);
    check({tag, "_count"}, got.size(), wr.size());
    for (int i = 0; i < wr.size() && i < got.size(); i++)
      check({tag, "_word"}, 32'(got[i]), 32'(wr[i]));
    got.delete();
    wr.delete();
  endtask

  task automatic fresh();
    got.delete();
    wr.delete();
  endtask

  initial begin
    // Reset held with a non-empty FIFO: nothing may be popped.
    #1;
    load(8'h11); load(8'h22); load(8'h33);
    drive_src();
    #1;
    check("rst_rinc", 32'(RINC), 0);
    check("rst_valid", 32'(OUT_VALID), 0);
    check("rst_occ", 32'(OCCUPANCY), 0);
    check("rst_data", 32'(OUT_DATA), 0);
    @(posedge R_CLK);
    #1;
    check("rst_hold_rinc", 32'(RINC), 0);
    R_RST = 1'b1;

    // Streaming: first cycle after release already pops.
    drain("stream", 10);
    cmp_seq("stream");

    // Stall: two pops then back-pressure, then in-order release.
    load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
    repeat (4) cycle(1'b0, 1'b0);
    drain("stall", 12);
    cmp_seq("stall");

    // Ready toggling with a continuously fed FIFO.
    for (int i = 0; i < 10; i++) load(8'(8'h30 + i));
    for (int i = 0; i < 16; i++) cycle(i[0] == 1'b0, 1'b0);
    drain("toggle", 20);
    cmp_seq("toggle");

    // Flush while two words are buffered; the following FIFO word comes next.
    src.push_back(8'h5A); src.push_back(8'h5B); src.push_back(8'h5C);
    fresh();
    repeat (2) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    wr.push_back(8'h5C);
    drain("flush", 10);
    cmp_seq("flush");

    // Async reset in the middle of a cycle while two words are buffered.
    src.push_back(8'h61); src.push_back(8'h62);
    src.push_back(8'h63); src.push_back(8'h64);
    repeat (2) cycle(1'b0, 1'b0);
    drive_src();
    #3;
    R_RST = 1'b0;
    #1;
    check("arst_valid", 32'(OUT_VALID), 0);
    check("arst_occ", 32'(OCCUPANCY), 0);
    check("arst_rinc", 32'(RINC), 0);
    check("arst_data", 32'(OUT_DATA), 0);
    loc.delete();
    @(posedge R_CLK);
    #1;
    R_RST = 1'b1;
    fresh();
    wr.push_back(8'h63); wr.push_back(8'h64);
    drain("arst", 10);
    cmp_seq("arst");

    // Random traffic: sporadic writes, random ready, rare flushes.
    fresh();
    for (int i = 0; i < 400; i++) begin
      if (src.size() < 6 && $urandom_range(0, 2) != 0) src.push_back(DW'($urandom));
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
    end
    drain("rand", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
